fp_mul_issue_retire: RTL and testbench
======================================

Name: fp_mul_issue_retire

Overview:
- Pipeline control wrapper around the combinational floating-point multiplier.
- Accepts operand pairs on a valid/ready interface and registers them into an issue stage that drives the multiplier.
- Captures the multiplier's result and exception vector into a retire stage, presented on a valid/ready output.
- Keeps a sticky 5-bit exception accumulator (fflags-style) for the surrounding FPU.

Parameters:
- exp_width, 19, exponent field width; must match the attached multiplier.
- frac_width, 237, fraction field width; must match the attached multiplier.
- tag_width, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  issue stage can accept this cycle.
- in_op1  input  exp_width+frac_width+1  operand 1.
- in_op2  input  exp_width+frac_width+1  operand 2.
- in_round_mode  input  2  rounding mode, encoding per FloatingPointConsts.svh.
- in_tag  input  tag_width  opaque tag.
- mul_op1  output  exp_width+frac_width+1  to multiplier op1; equals issue register.
- mul_op2  output  exp_width+frac_width+1  to multiplier op2.
- mul_round_mode  output  2  to multiplier round_mode.
- mul_result  input  exp_width+frac_width+1  from multiplier result.
- mul_exception  input  5  from multiplier exception.
- out_valid  output  1  retire stage holds a result.
- out_ready  input  1  consumer accepts.
- out_result  output  exp_width+frac_width+1  registered result.
- out_exception  output  5  registered exception vector.
- out_tag  output  tag_width  tag of retired op.
- flags_clear  input  1  clear sticky flags.
- flags_sticky  output  5  OR of out_exception over all retired ops since the last clear or reset.

Behaviour:
- State: issue stage (s1_valid, op1, op2, round_mode, tag) and retire stage (s2_valid, result, exception, tag).
- Reset values: s1_valid=0, s2_valid=0, out_valid=0, all data registers 0, flags_sticky=0.
- Reset mid-operation drops in-flight ops silently; nothing is retired and no flags are set.
- Outputs mul_* are driven directly from the issue registers. The multiplier is combinational, so its outputs are sampled in the same cycle.
- Stall/advance signals:
  - s2_free = !s2_valid | out_ready.
  - s1_adv = s1_valid & s2_free.
  - in_ready = !s1_valid | s2_free. This is a combinational dependency on out_ready (documented; no skid).
- Issue stage:
  - in_valid & in_ready: load in_* into issue, s1_valid=1.
  - else if s1_adv: s1_valid=0.
  - else hold.
- Retire stage:
  - s1_adv: load mul_result, mul_exception, issue tag; s2_valid=1.
  - else if out_valid & out_ready: s2_valid=0.
  - else hold, with all out_* stable while out_valid & !out_ready.
- Latency and throughput:
  - Accept in cycle N gives out_valid in cycle N+2 when unstalled.
  - Full throughput: one op per cycle sustained when out_ready=1.
- Ordering is strictly in-order; the tag is passed through unmodified.
- Sticky flags, evaluated at each rising edge:
  - flags_sticky = (flags_clear ? 0 : flags_sticky) | (out_valid & out_ready ? out_exception : 0).
  - Clear and retire in the same cycle: the result is the retiring op's bits only.
- Backpressure boundary: with both stages full and out_ready=0, in_ready=0. When out_ready rises, both stages advance in the same cycle and in_ready=1 that cycle.
- No arithmetic in this block. Widths pass through unchanged.

Optional Feature:
- Macro: FP_MUL_ISSUE_PERF_EN.
- Defined: adds outputs perf_retired[31:0] and perf_stall[31:0], both reset to 0.
  - perf_retired increments on each out_valid & out_ready.
  - perf_stall increments on each cycle with out_valid & !out_ready.
  - Both wrap modulo 2^32 (0xFFFFFFFF→0).
  - Neither is affected by flags_clear.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan (bench configures exp_width=8, frac_width=23, multiplier instance attached, round mode RNE):
- Single op: in 0x3FC00000 × 0x40000000, tag 3, out_ready=1 → out_valid exactly 2 cycles after accept; result 0x40400000, exception 0, tag 3, flags_sticky 0.
- Overflow plus sticky: 0x7F000000 × 0x7F000000, then 0x3F800000 × 0x3F800000 → first result 0x7F800000 with overflow bit set. flags_sticky keeps the overflow bit after the second retire (result 0x3F800000).
- Backpressure: stream 4 ops with out_ready=0 for 5 cycles → in_ready=0 once 2 ops are held, out_* stable. Releasing out_ready delivers all 4 in order with tags 0-3, one per cycle.
- Clear vs retire collision: 0x3F800001 × 0x3F800001 retires in the same cycle as flags_clear=1, with prior flags showing overflow → result 0x3F800002. flags_sticky afterwards has only the inexact bit set.
- Reset mid-flight: assert reset for 1 cycle with both stages valid → next cycle out_valid=0, in_ready=1, flags_sticky=0; no retire occurs.
- FP_MUL_ISSUE_PERF_EN: 3 retires plus 2 stalled cycles → perf_retired=3, perf_stall=2. Preload near-wrap via 2^32 stalls is not required; force-check wrap at 0xFFFFFFFF→0.

Source files
------------

// File: rtl/fp_mul_issue_retire.sv
// fp_mul_issue_retire: two-stage valid/ready control wrapper around a
// combinational floating-point multiplier. The issue stage registers an
// operand pair and drives the multiplier directly. The retire stage captures
// the multiplier's result and exception vector. A sticky 5-bit exception
// accumulator collects exceptions from every retired op.
// Optional feature macro: FP_MUL_ISSUE_PERF_EN adds the perf_retired and
// perf_stall counters.
module fp_mul_issue_retire #(
  parameter int exp_width  = 19,
  parameter int frac_width = 237,
  parameter int tag_width  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  // operand side
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [exp_width+frac_width:0] in_op1,
  input  logic [exp_width+frac_width:0] in_op2,
  input  logic [1:0]                    in_round_mode,
  input  logic [tag_width-1:0]          in_tag,
  // attached combinational multiplier
  output logic [exp_width+frac_width:0] mul_op1,
  output logic [exp_width+frac_width:0] mul_op2,
  output logic [1:0]                    mul_round_mode,
  input  logic [exp_width+frac_width:0] mul_result,
  input  logic [4:0]                    mul_exception,
  // result side
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [exp_width+frac_width:0] out_result,
  output logic [4:0]                    out_exception,
  output logic [tag_width-1:0]          out_tag,
  // sticky exception flags
  input  logic                          flags_clear,
  output logic [4:0]                    flags_sticky
`ifdef FP_MUL_ISSUE_PERF_EN
  ,
  output logic [31:0]                   perf_retired,
  output logic [31:0]                   perf_stall
`endif
);

  localparam int W = exp_width + frac_width + 1;

  // Issue stage
  logic                 s1_valid_q, s1_valid_d;
  logic [W-1:0]         s1_op1_q, s1_op1_d;
  logic [W-1:0]         s1_op2_q, s1_op2_d;
  logic [1:0]           s1_rm_q, s1_rm_d;
  logic [tag_width-1:0] s1_tag_q, s1_tag_d;

  // Retire stage
  logic                 s2_valid_q, s2_valid_d;
  logic [W-1:0]         s2_result_q, s2_result_d;
  logic [4:0]           s2_exc_q, s2_exc_d;
  logic [tag_width-1:0] s2_tag_q, s2_tag_d;

  logic [4:0]           flags_q, flags_d;

  logic s2_free, s1_adv, in_fire, out_fire;

  // The retire stage can take a new op when it is empty or draining this
  // cycle; in_ready therefore depends combinationally on out_ready (no skid).
  assign s2_free  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  // Issue stage next state: load on accept, empty on advance, else hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    s1_valid_d = s1_valid_q;
    s1_op1_d   = s1_op1_q;
    s1_op2_d   = s1_op2_q;
    s1_rm_d    = s1_rm_q;
    s1_tag_d   = s1_tag_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_op1_d   = in_op1;
      s1_op2_d   = in_op2;
      s1_rm_d    = in_round_mode;
      s1_tag_d   = in_tag;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Retire stage next state: capture multiplier output on advance, empty on
  // handshake, otherwise hold so out_* stay stable under backpressure.
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_exc_d    = s2_exc_q;
    s2_tag_d    = s2_tag_q;
    if (s1_adv) begin
      s2_valid_d  = 1'b1;
      s2_result_d = mul_result;
      s2_exc_d    = mul_exception;
      s2_tag_d    = s1_tag_q;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  // Sticky flags: clear takes effect first, so a retire in the same cycle
  // leaves exactly the retiring op's exception bits.
  always_comb begin
    flags_d = (flags_clear ? 5'd0 : flags_q) | (out_fire ? s2_exc_q : 5'd0);
  end

  // Pipeline and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: data registers are plain flops (no memory array), so they are
      // reset as well and the outputs never show X after reset.
      s1_valid_q  <= 1'b0;
      s1_op1_q    <= '0;
      s1_op2_q    <= '0;
      s1_rm_q     <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_exc_q    <= '0;
      s2_tag_q    <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op1_q    <= s1_op1_d;
      s1_op2_q    <= s1_op2_d;
      s1_rm_q     <= s1_rm_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_exc_q    <= s2_exc_d;
      s2_tag_q    <= s2_tag_d;
      flags_q     <= flags_d;
    end
  end

  assign mul_op1        = s1_op1_q;
  assign mul_op2        = s1_op2_q;
  assign mul_round_mode = s1_rm_q;
  assign out_valid      = s2_valid_q;
  assign out_result     = s2_result_q;
  assign out_exception  = s2_exc_q;
  assign out_tag        = s2_tag_q;
  assign flags_sticky   = flags_q;

`ifdef FP_MUL_ISSUE_PERF_EN
  logic [31:0] perf_retired_q, perf_retired_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Performance counters wrap naturally modulo 2^32.
  always_comb begin
    perf_retired_d = perf_retired_q + (out_fire ? 32'd1 : 32'd0);
    perf_stall_d   = perf_stall_q + ((s2_valid_q && !out_ready) ? 32'd1 : 32'd0);
  end

  // Performance counter registers; untouched by flags_clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_retired_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fp_mul_issue_retire.sv
// Self-checking bench for fp_mul_issue_retire configured for binary32.
// A behavioural stand-in for the multiplier drives mul_result/mul_exception
// from mul_op*. Exception bit order is {NV, DZ, OF, UF, NX}.
module tb_fp_mul_issue_retire;

  localparam int EW = 8;
  localparam int FW = 23;
  localparam int TW = 4;

  localparam logic [4:0] EXC_NONE = 5'b00000;
  localparam logic [4:0] EXC_NX   = 5'b00001;
  localparam logic [4:0] EXC_OFNX = 5'b00101;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_op1, in_op2;
  logic [1:0]    in_round_mode;
  logic [TW-1:0] in_tag;
  logic [31:0]   mul_op1, mul_op2;
  logic [1:0]    mul_round_mode;
  logic [31:0]   mul_result;
  logic [4:0]    mul_exception;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_result;
  logic [4:0]    out_exception;
  logic [TW-1:0] out_tag;
  logic          flags_clear;
  logic [4:0]    flags_sticky;
`ifdef FP_MUL_ISSUE_PERF_EN
  logic [31:0]   perf_retired, perf_stall;
`endif

  always #5 clk = ~clk;

  fp_mul_issue_retire #(.exp_width(EW), .frac_width(FW), .tag_width(TW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_round_mode(in_round_mode), .in_tag(in_tag),
    .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_round_mode(mul_round_mode),
    .mul_result(mul_result), .mul_exception(mul_exception),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_exception(out_exception), .out_tag(out_tag),
    .flags_clear(flags_clear), .flags_sticky(flags_sticky)
`ifdef FP_MUL_ISSUE_PERF_EN
    , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
  );

  // Multiplier stand-in: exact products for the directed binary32 vectors,
  // an asymmetric scramble (sensitive to operand order and rounding mode)
  // for everything else.
  function automatic logic [36:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] rm);
    logic [36:0] r;
    case ({a, b})
      {32'h3FC00000, 32'h40000000}: r = {32'h40400000, EXC_NONE};
      {32'h7F000000, 32'h7F000000}: r = {32'h7F800000, EXC_OFNX};
      {32'h3F800000, 32'h3F800000}: r = {32'h3F800000, EXC_NONE};
      {32'h3F800001, 32'h3F800001}: r = {32'h3F800002, EXC_NX};
      default: r = {a + {b[15:0], b[31:16]} + {30'd0, rm}, a[4:0] ^ b[9:5] ^ {3'b000, rm}};
    endcase
    return r;
  endfunction

  assign {mul_result, mul_exception} = mul_model(mul_op1, mul_op2, mul_round_mode);

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and flag model, sampled on the falling edge.
  typedef struct {
    logic [31:0]   res;
    logic [4:0]    exc;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t       sb_q[$];
  logic [4:0] model_flags = 5'd0;
  bit         mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t       e;
      logic [4:0] ret_exc;
      logic [36:0] m;
      check("flags_model", flags_sticky, model_flags);
      if (reset) begin
        sb_q.delete();
        model_flags = 5'd0;
      end else begin
        ret_exc = 5'd0;
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected_retire: got tag 0x%0h expected no retire", out_tag);
          end else begin
            e = sb_q.pop_front();
            check("sb_result", out_result, e.res);
            check("sb_exception", out_exception, e.exc);
            check("sb_tag", out_tag, e.tag);
            ret_exc = e.exc;
          end
        end
        if (in_valid && in_ready) begin
          m = mul_model(in_op1, in_op2, in_round_mode);
          e.res = m[36:5];
          e.exc = m[4:0];
          e.tag = in_tag;
          sb_q.push_back(e);
        end
        model_flags = (flags_clear ? 5'd0 : model_flags) | ret_exc;
      end
    end
  end

  // Directed single-op vectors, each retired with out_ready=1.
  typedef struct {
    logic [31:0]   op1;
    logic [31:0]   op2;
    logic [TW-1:0] tag;
    logic          clr;
    logic [31:0]   res;
    logic [4:0]    exc;
    logic [4:0]    flags_after;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [31:0] gen_op(input int i, input int k);
    return 32'h1357_9BDF ^ (32'(i) * 32'h0F0F_1111) ^ (32'(k) * 32'h2040_8001);
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [4:0]    prev_flags;
    logic [31:0]   cap_res;
    logic [TW-1:0] cap_tag;
    int            lat;

    vecs[0] = '{32'h3FC00000, 32'h40000000, 4'd3, 1'b0, 32'h40400000, EXC_NONE, EXC_NONE};
    vecs[1] = '{32'h7F000000, 32'h7F000000, 4'd5, 1'b0, 32'h7F800000, EXC_OFNX, EXC_OFNX};
    vecs[2] = '{32'h3F800000, 32'h3F800000, 4'd6, 1'b0, 32'h3F800000, EXC_NONE, EXC_OFNX};
    vecs[3] = '{32'h3F800001, 32'h3F800001, 4'd7, 1'b1, 32'h3F800002, EXC_NX,   EXC_NX};

    reset = 1'b1; in_valid = 1'b0; in_op1 = '0; in_op2 = '0;
    in_round_mode = 2'd0; in_tag = '0; out_ready = 1'b0; flags_clear = 1'b0;

    // Reset state
    tick();
    mon_en = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_flags", flags_sticky, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_mul_op1", mul_op1, 0);
    tick();
    reset = 1'b0;

    // Directed vectors: latency, pass-through, sticky and clear/retire collision
    prev_flags = 5'd0;
    foreach (vecs[i]) begin
      in_op1 = vecs[i].op1; in_op2 = vecs[i].op2; in_tag = vecs[i].tag;
      in_round_mode = 2'd0; in_valid = 1'b1; out_ready = 1'b1;
      #1 check("vec_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      check("vec_mul_op1", mul_op1, vecs[i].op1);
      check("vec_mul_op2", mul_op2, vecs[i].op2);
      check("vec_early_valid", out_valid, 0);
      lat = 0;
      while (!out_valid && lat < 10) begin
        tick();
        lat++;
      end
      check("vec_latency", lat, 1);
      check("vec_result", out_result, vecs[i].res);
      check("vec_exception", out_exception, vecs[i].exc);
      check("vec_tag", out_tag, vecs[i].tag);
      check("vec_flags_before", flags_sticky, prev_flags);
      flags_clear = vecs[i].clr;
      tick();
      flags_clear = 1'b0;
      check("vec_flags_after", flags_sticky, vecs[i].flags_after);
      check("vec_drained", out_valid, 0);
      prev_flags = vecs[i].flags_after;
    end

    // Backpressure: two ops fill both stages, third is refused
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_op1 = gen_op(i, 1); in_op2 = gen_op(i, 2); in_round_mode = 2'(i);
      in_tag = TW'(i); in_valid = 1'b1;
      tick();
    end
    in_op1 = gen_op(2, 1); in_op2 = gen_op(2, 2); in_round_mode = 2'd2; in_tag = 4'd2;
    #1 check("bp_in_ready_full", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_first_tag", out_tag, 0);
    cap_res = out_result;
    cap_tag = out_tag;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("bp_hold_in_ready", in_ready, 0);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_result", out_result, cap_res);
      check("bp_hold_tag", out_tag, cap_tag);
    end
    out_ready = 1'b1;
    #1 check("bp_release_in_ready", in_ready, 1);
    tick();
    in_op1 = gen_op(3, 1); in_op2 = gen_op(3, 2); in_round_mode = 2'd3; in_tag = 4'd3;
    check("bp_stream_valid1", out_valid, 1);
    check("bp_stream_tag1", out_tag, 1);
    tick();
    in_valid = 1'b0;
    check("bp_stream_valid2", out_valid, 1);
    check("bp_stream_tag2", out_tag, 2);
    tick();
    check("bp_stream_valid3", out_valid, 1);
    check("bp_stream_tag3", out_tag, 3);
    tick();
    check("bp_stream_done", out_valid, 0);

    // Reset mid-flight with both stages valid
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_op1 = gen_op(i, 5); in_op2 = gen_op(i, 6); in_tag = TW'(8 + i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #1 check("mid_full_in_ready", in_ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_out_valid", out_valid, 0);
    check("mid_in_ready", in_ready, 1);
    check("mid_flags", flags_sticky, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("mid_no_retire", out_valid, 0);
    end

`ifdef FP_MUL_ISSUE_PERF_EN
    // Performance counters: one op stalled for 2 cycles, then 3 retires total
    out_ready = 1'b0;
    in_op1 = gen_op(0, 9); in_op2 = gen_op(1, 9); in_tag = 4'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      in_op1 = gen_op(i, 10); in_op2 = gen_op(i, 11); in_tag = TW'(2 + i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("perf_retired", perf_retired, 32'd3);
    check("perf_stall", perf_stall, 32'd2);
    // Wrap: preload the retire counter at all-ones, then retire once more
    in_op1 = gen_op(7, 12); in_op2 = gen_op(7, 13); in_tag = 4'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    force dut.perf_retired_q = 32'hFFFF_FFFF;
    #1 release dut.perf_retired_q;
    tick();
    tick();
    check("perf_retired_wrap", perf_retired, 32'd0);
`endif

    repeat (2) tick();
    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
